// File: rtl/program_memory_arbiter_pkg.sv
// Shared types and constants for the program memory arbiter slice.
package program_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_F = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_F = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [31:0] PM_BASE_ADDR_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/program_memory_arbiter_addr_check.sv
// Combinational range/alignment check of a byte address against the program memory window.
module pm_addr_check
  import program_memory_arbiter_pkg::*;
#(
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(PM_BASE_ADDR_DEFAULT)
) (
  input  logic [DATA_WIDTH-1:0] addr,
  output logic                  valid
);

  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] offset;

  // The lower-bound test guards the unsigned subtraction against wrapping.
  always_comb begin
    offset = addr - BASE_ADDR;
    valid  = (addr >= BASE_ADDR) && (offset < SPAN) && (addr[1:0] == 2'b00);
  end

endmodule

// File: rtl/program_memory_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a combinational program memory, fully registered outputs.
module program_memory_arbiter
  import program_memory_arbiter_pkg::*;
#(
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(PM_BASE_ADDR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req_i,
  input  logic [DATA_WIDTH-1:0] f_addr_i,
  input  logic                  d_req_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  output logic                  f_gnt_o,
  output logic                  d_gnt_o,
  output logic                  f_rvalid_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [7:0]            conflict_cnt_o
);

  state_t                state, state_next;
  owner_t                last_owner;
  logic                  grant_f, grant_d;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic                  sel_valid;
  logic                  addr_ok;

  always_comb begin
    state_next = IDLE;
    grant_f    = 1'b0;
    grant_d    = 1'b0;
    if (f_req_i && (!d_req_i || last_owner == OWNER_D)) begin
      grant_f    = 1'b1;
      state_next = SERVE_F;
    end else if (d_req_i) begin
      grant_d    = 1'b1;
      state_next = SERVE_D;
    end
  end

  assign sel_addr = grant_d ? d_addr_i : f_addr_i;

  pm_addr_check #(
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .BASE_ADDR    (BASE_ADDR)
  ) u_addr_check (
    .addr  (sel_addr),
    .valid (sel_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_owner     <= OWNER_D;
      f_gnt_o        <= 1'b0;
      d_gnt_o        <= 1'b0;
      f_rvalid_o     <= 1'b0;
      d_rvalid_o     <= 1'b0;
      err_o          <= 1'b0;
      rdata_o        <= '0;
      mem_addr_o     <= BASE_ADDR;
      addr_ok        <= 1'b0;
      conflict_cnt_o <= '0;
    end else begin
      state   <= state_next;
      f_gnt_o <= grant_f;
      d_gnt_o <= grant_d;
      if (grant_f || grant_d) begin
        mem_addr_o <= sel_addr;
        addr_ok    <= sel_valid;
        last_owner <= grant_f ? OWNER_F : OWNER_D;
      end
      // Response stage: the memory answers for mem_addr_o during the SERVE cycle.
      f_rvalid_o <= (state == SERVE_F);
      d_rvalid_o <= (state == SERVE_D);
      err_o      <= (state != IDLE) && !addr_ok;
      if (state != IDLE) begin
        rdata_o <= addr_ok ? mem_rdata_i : '0;
      end
      if (f_req_i && d_req_i && conflict_cnt_o != 8'hFF) begin
        conflict_cnt_o <= conflict_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Randomized self-checking bench for program_memory_arbiter against a transaction-level reference model.
module tb_program_memory_arbiter;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        f_req = 1'b0, d_req = 1'b0;
  logic [31:0] f_addr = BASE, d_addr = BASE;
  logic        f_gnt, d_gnt, f_rvalid, d_rvalid, err;
  logic [31:0] rdata, mem_addr, mem_rdata, moff;
  logic [7:0]  cnt;
  logic [31:0] mem [DEPTH];

  always #5 clk = ~clk;

  program_memory_arbiter #(
    .MEMORY_DEPTH (DEPTH),
    .DATA_WIDTH   (32),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .f_req_i        (f_req),
    .f_addr_i       (f_addr),
    .d_req_i        (d_req),
    .d_addr_i       (d_addr),
    .f_gnt_o        (f_gnt),
    .d_gnt_o        (d_gnt),
    .f_rvalid_o     (f_rvalid),
    .d_rvalid_o     (d_rvalid),
    .rdata_o        (rdata),
    .err_o          (err),
    .mem_addr_o     (mem_addr),
    .mem_rdata_i    (mem_rdata),
    .conflict_cnt_o (cnt)
  );

  // Program memory: any word-ish offset inside the window returns that word, outside returns junk.
  assign moff      = mem_addr - BASE;
  assign mem_rdata = (moff < 32'd256) ? mem[moff[7:2]] : 32'hDEAD_BEEF;

  typedef struct {
    int          due;
    bit          is_f;
    logic [31:0] data;
    bit          err;
  } resp_t;

  resp_t       rq[$];
  bit          m_last_f;
  bit          e_fg, e_dg;
  logic [31:0] e_addr;
  int          e_cnt;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(DEPTH)) && (la % 4 == 0);
  endfunction

  task automatic model_reset();
    rq.delete();
    m_last_f = 1'b0;
    e_fg     = 1'b0;
    e_dg     = 1'b0;
    e_addr   = BASE;
    e_cnt    = 0;
  endtask

  task automatic model_step();
    resp_t r;
    bit    sel_f;
    int    idx;
    if (f_req || d_req) begin
      sel_f  = f_req && (!d_req || !m_last_f);
      r.due  = cyc + 2;
      r.is_f = sel_f;
      e_addr = sel_f ? f_addr : d_addr;
      r.err  = !in_window(e_addr);
      idx    = int'((longint'(e_addr) - longint'(BASE)) / 4);
      r.data = r.err ? 32'h0 : mem[idx];
      rq.push_back(r);
      e_fg     = sel_f;
      e_dg     = !sel_f;
      m_last_f = sel_f;
    end else begin
      e_fg = 1'b0;
      e_dg = 1'b0;
    end
    if (f_req && d_req && e_cnt < 255) e_cnt++;
  endtask

  task automatic compare();
    resp_t r;
    bit    hit;
    hit = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r   = rq.pop_front();
      hit = 1'b1;
    end
    chk("f_gnt", 32'(f_gnt), 32'(e_fg));
    chk("d_gnt", 32'(d_gnt), 32'(e_dg));
    chk("f_rvalid", 32'(f_rvalid), 32'(hit && r.is_f));
    chk("d_rvalid", 32'(d_rvalid), 32'(hit && !r.is_f));
    chk("err", 32'(err), 32'(hit && r.err));
    if (hit) chk("rdata", rdata, r.data);
    chk("mem_addr", mem_addr, e_addr);
    chk("conflict_cnt", 32'(cnt), 32'(e_cnt));
  endtask

  task automatic cycle(input bit f, input logic [31:0] fa, input bit d, input logic [31:0] da, input bit r);
    @(posedge clk);
    #1;
    reset  = r;
    f_req  = f;
    f_addr = fa;
    d_req  = d;
    d_addr = da;
    @(negedge clk);
    if (r) model_reset();
    compare();
    if (!r) model_step();
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b0, BASE, 1'b0, BASE, 1'b0);
  endtask

  task automatic rst();
    cycle(1'b0, BASE, 1'b0, BASE, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      3:       return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      4:       return ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'(4 * DEPTH);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    model_reset();

    rst();
    chk("rst_cnt_lit", 32'(cnt), 32'h0);
    chk("rst_addr_lit", mem_addr, 32'h0040_0000);

    // Single fetch of word 1.
    cycle(1'b1, 32'h0040_0004, 1'b0, BASE, 1'b0);
    idle();
    chk("single_fgnt_lit", 32'(f_gnt), 32'h1);
    idle();
    chk("single_frv_lit", 32'(f_rvalid), 32'h1);
    chk("single_rdata_lit", rdata, 32'hC0DE_0001);
    chk("single_err_lit", 32'(err), 32'h0);

    // Continuous contention from reset: F wins first, then strict alternation.
    rst();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 32'h0040_0004, 1'b1, 32'h0040_0008, 1'b0);
      chk("alt_cnt_lit", 32'(cnt), 32'(k));
      if (k >= 1) begin
        chk("alt_fgnt_lit", 32'(f_gnt), 32'(k % 2 == 1));
        chk("alt_dgnt_lit", 32'(d_gnt), 32'(k % 2 == 0));
      end
      if (k == 2) chk("alt_frdata_lit", rdata, 32'hC0DE_0001);
      if (k == 3) begin
        chk("alt_drv_lit", 32'(d_rvalid), 32'h1);
        chk("alt_drdata_lit", rdata, 32'hC0DE_0002);
      end
    end

    // Out-of-range and misaligned data accesses.
    rst();
    cycle(1'b0, BASE, 1'b1, 32'h0040_0100, 1'b0);
    idle();
    idle();
    chk("oor_drv_lit", 32'(d_rvalid), 32'h1);
    chk("oor_err_lit", 32'(err), 32'h1);
    chk("oor_rdata_lit", rdata, 32'h0);
    cycle(1'b0, BASE, 1'b1, 32'h0040_0002, 1'b0);
    idle();
    idle();
    chk("mis_err_lit", 32'(err), 32'h1);
    chk("mis_rdata_lit", rdata, 32'h0);
    idle();
    chk("err_low_lit", 32'(err), 32'h0);

    // Reset during the SERVE_F cycle drops the response.
    rst();
    cycle(1'b1, 32'h0040_0004, 1'b0, BASE, 1'b0);
    rst();
    chk("midrst_fgnt_lit", 32'(f_gnt), 32'h0);
    idle();
    chk("midrst_frv_lit", 32'(f_rvalid), 32'h0);
    idle();
    chk("midrst_frv2_lit", 32'(f_rvalid), 32'h0);
    cycle(1'b1, 32'h0040_0004, 1'b1, 32'h0040_0008, 1'b0);
    idle();
    chk("midrst_tie_lit", 32'(f_gnt), 32'h1);

    // Counter saturation.
    rst();
    for (int k = 0; k < 300; k++) cycle(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0014, 1'b0);
    chk("sat_lit", 32'(cnt), 32'hFF);
    cycle(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0014, 1'b0);
    chk("sat_hold_lit", 32'(cnt), 32'hFF);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 99) < 60, rand_addr(), $urandom_range(0, 99) < 60, rand_addr(),
            $urandom_range(0, 149) == 0);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
